// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle main controller and its datapath.
//
// Datapath -> controller : instr_op_i, funct_i, zero_i, lt_i, mem_ready_i
// Controller -> datapath : pc_write_o, pc_src_o, ir_write_o, i_or_d_o,
//                          mem_read_o, mem_write_o, reg_write_o, reg_dst_o,
//                          mem_to_reg_o, alu_src_a_o, alu_src_b_o, alu_op_o,
//                          state_o, illegal_o, retired_o
//
// Modports: master = the controller (drives the control word),
//           slave  = the datapath (drives instruction fields and status).
// Handshake: mem_ready_i is a completion strobe. While a memory request
// (mem_read_o/mem_write_o) is high, the access completes on the clock edge
// at which mem_ready_i is 1. The request is held, unchanged, until then.
interface multicycle_ctrl_fsm_if #(
  parameter int OP_W    = 6,
  parameter int FUNCT_W = 6,
  parameter int CNT_W   = 32
);
  logic [OP_W-1:0]    instr_op_i;
  logic [FUNCT_W-1:0] funct_i;
  logic               zero_i;
  logic               lt_i;
  logic               mem_ready_i;

  logic               pc_write_o;
  logic [1:0]         pc_src_o;
  logic               ir_write_o;
  logic               i_or_d_o;
  logic               mem_read_o;
  logic               mem_write_o;
  logic               reg_write_o;
  logic [1:0]         reg_dst_o;
  logic [1:0]         mem_to_reg_o;
  logic               alu_src_a_o;
  logic [1:0]         alu_src_b_o;
  logic [4:0]         alu_op_o;
  logic [3:0]         state_o;
  logic               illegal_o;
  logic [CNT_W-1:0]   retired_o;

  modport master (
    input  instr_op_i, funct_i, zero_i, lt_i, mem_ready_i,
    output pc_write_o, pc_src_o, ir_write_o, i_or_d_o, mem_read_o,
           mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           retired_o
  );

  modport slave (
    output instr_op_i, funct_i, zero_i, lt_i, mem_ready_i,
    input  pc_write_o, pc_src_o, ir_write_o, i_or_d_o, mem_read_o,
           mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, state_o, illegal_o,
           retired_o
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle main control unit for the MIPS-subset datapath.
// Moore FSM sequencing fetch / decode / execute / memory / writeback,
// stalling on mem_ready_i, holding MUL for MUL_CYCLES execute cycles,
// counting retired instructions and pulsing illegal_o on unknown opcodes.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous, active-low reset
//   bus    - multicycle_ctrl_fsm_if.master (instruction fields and status
//            in, control word, debug state, illegal pulse, retired count out)
module multicycle_ctrl_fsm #(
  parameter int OP_W        = 6,
  parameter int FUNCT_W     = 6,
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_WAIT_EN = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  multicycle_ctrl_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_MUL = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_ALU   = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    JAL_WB   = 4'd12,
    JR       = 4'd13
  } state_t;

  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_BNEZ = OP_W'(6'h01);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6'h06);
  localparam logic [OP_W-1:0] OP_BLE  = OP_W'(6'h07);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0D);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'h0F);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);

  localparam logic [FUNCT_W-1:0] FN_JR  = FUNCT_W'(6'h08);
  localparam logic [FUNCT_W-1:0] FN_MUL = FUNCT_W'(6'h18);

  localparam int MC_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MUL_CYCLES - 1);

  state_t           state, state_next;
  logic [MC_W-1:0]  mul_cnt;
  logic [CNT_W-1:0] retired;

  // Memory completion as seen by the FSM.
  logic mem_rdy;
  assign mem_rdy = (MEM_WAIT_EN != 0) ? bus.mem_ready_i : 1'b1;

  // Unmasked control word, gated by reset below.
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write;
  logic       alu_src_a, illegal, retire;
  logic [1:0] pc_src, reg_dst, mem_to_reg, alu_src_b;
  logic [4:0] alu_op;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state   <= FETCH;
      mul_cnt <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      // Counter restarts whenever EXEC_MUL is not occupied, so each entry
      // always sees a fresh MUL_CYCLES window.
      if (state == EXEC_MUL) mul_cnt <= mul_cnt + MC_W'(1);
      else                   mul_cnt <= '0;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    state_next = state;
    pc_write   = 1'b0;
    pc_src     = 2'd0;
    ir_write   = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 5'd0;
    illegal    = 1'b0;
    retire     = 1'b0;

    unique case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_rdy) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = DECODE;
        end
      end

      DECODE: begin
        // Branch target precomputed into ALUOut during decode.
        alu_src_b = 2'd3;
        if (bus.instr_op_i == OP_R) begin
          if (bus.funct_i == FN_MUL)     state_next = EXEC_MUL;
          else if (bus.funct_i == FN_JR) state_next = JR;
          else                           state_next = EXEC_R;
        end else if (bus.instr_op_i == OP_ADDI || bus.instr_op_i == OP_ORI ||
                     bus.instr_op_i == OP_LUI) begin
          state_next = EXEC_I;
        end else if (bus.instr_op_i == OP_LW || bus.instr_op_i == OP_SW) begin
          state_next = MEM_ADDR;
        end else if (bus.instr_op_i == OP_BNEZ || bus.instr_op_i == OP_BEQ ||
                     bus.instr_op_i == OP_BNE  || bus.instr_op_i == OP_BLT ||
                     bus.instr_op_i == OP_BLE) begin
          state_next = BRANCH;
        end else if (bus.instr_op_i == OP_J) begin
          state_next = JUMP;
        end else if (bus.instr_op_i == OP_JAL) begin
          state_next = JAL_WB;
        end else begin
          illegal    = 1'b1;
          state_next = FETCH;
        end
      end

      EXEC_R: begin
        alu_src_a  = 1'b1;
        alu_op     = 5'd2;
        state_next = WB_ALU;
      end

      EXEC_MUL: begin
        alu_src_a = 1'b1;
        alu_op    = 5'd2;
        if (mul_cnt == MUL_LAST) state_next = WB_ALU;
      end

      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        if (bus.instr_op_i == OP_ORI)      alu_op = 5'd4;
        else if (bus.instr_op_i == OP_LUI) alu_op = 5'd5;
        else                               alu_op = 5'd0;
        state_next = WB_ALU;
      end

      WB_ALU: begin
        reg_write  = 1'b1;
        reg_dst    = (bus.instr_op_i == OP_R) ? 2'd1 : 2'd0;
        retire     = 1'b1;
        state_next = FETCH;
      end

      MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        state_next = (bus.instr_op_i == OP_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_rdy) state_next = WB_MEM;
      end

      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'd1;
        retire     = 1'b1;
        state_next = FETCH;
      end

      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_rdy) begin
          retire     = 1'b1;
          state_next = FETCH;
        end
      end

      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 5'd1;
        pc_src    = 2'd1;
        // BNEZ is BNE against $0, so both use the not-equal test.
        if (bus.instr_op_i == OP_BEQ)      pc_write = bus.zero_i;
        else if (bus.instr_op_i == OP_BNE ||
                 bus.instr_op_i == OP_BNEZ) pc_write = ~bus.zero_i;
        else if (bus.instr_op_i == OP_BLT) pc_write = bus.lt_i;
        else if (bus.instr_op_i == OP_BLE) pc_write = bus.lt_i | bus.zero_i;
        else                               pc_write = 1'b0;
        retire     = 1'b1;
        state_next = FETCH;
      end

      JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        retire     = 1'b1;
        state_next = FETCH;
      end

      JAL_WB: begin
        pc_write   = 1'b1;
        pc_src     = 2'd2;
        reg_write  = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        retire     = 1'b1;
        state_next = FETCH;
      end

      JR: begin
        pc_write   = 1'b1;
        pc_src     = 2'd3;
        retire     = 1'b1;
        state_next = FETCH;
      end

      default: state_next = FETCH;
    endcase
  end

  // While reset is held every output except the debug state is forced low,
  // so an instruction abandoned by reset cannot write anything.
  assign bus.pc_write_o   = rst_i & pc_write;
  assign bus.pc_src_o     = rst_i ? pc_src : 2'd0;
  assign bus.ir_write_o   = rst_i & ir_write;
  assign bus.i_or_d_o     = rst_i & i_or_d;
  assign bus.mem_read_o   = rst_i & mem_read;
  assign bus.mem_write_o  = rst_i & mem_write;
  assign bus.reg_write_o  = rst_i & reg_write;
  assign bus.reg_dst_o    = rst_i ? reg_dst : 2'd0;
  assign bus.mem_to_reg_o = rst_i ? mem_to_reg : 2'd0;
  assign bus.alu_src_a_o  = rst_i & alu_src_a;
  assign bus.alu_src_b_o  = rst_i ? alu_src_b : 2'd0;
  assign bus.alu_op_o     = rst_i ? alu_op : 5'd0;
  assign bus.illegal_o    = rst_i & illegal;
  assign bus.retired_o    = rst_i ? retired : '0;
  assign bus.state_o      = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: reset checks, a table of per-instruction
// expectations (cycle count, branch outcome, illegal pulse, retire delta),
// hand sequences for memory stall and reset-during-store, and randomized
// instructions compared cycle by cycle against a per-instruction cycle plan.
module tb_multicycle_ctrl_fsm;

  localparam int MUL_CYCLES = 4;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [4:0] alu_op;
    logic       illegal;
  } ctrl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       lt;
    int         wm;
    int         cycles;
    int         ret;
    logic       pcw;
    logic       ill;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if #(.OP_W(6), .FUNCT_W(6), .CNT_W(32)) bus ();

  multicycle_ctrl_fsm #(
    .OP_W(6), .FUNCT_W(6), .MUL_CYCLES(MUL_CYCLES), .MEM_WAIT_EN(1), .CNT_W(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_ret = 0;
  logic [24:0] exp_q[$];
  logic        rdy_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic ctrl_t dut_word();
    ctrl_t w;
    w.state      = bus.state_o;
    w.pc_write   = bus.pc_write_o;
    w.pc_src     = bus.pc_src_o;
    w.ir_write   = bus.ir_write_o;
    w.i_or_d     = bus.i_or_d_o;
    w.mem_read   = bus.mem_read_o;
    w.mem_write  = bus.mem_write_o;
    w.reg_write  = bus.reg_write_o;
    w.reg_dst    = bus.reg_dst_o;
    w.mem_to_reg = bus.mem_to_reg_o;
    w.alu_src_a  = bus.alu_src_a_o;
    w.alu_src_b  = bus.alu_src_b_o;
    w.alu_op     = bus.alu_op_o;
    w.illegal    = bus.illegal_o;
    return w;
  endfunction

  // ---------------- reference model ----------------
  function automatic bit known_op(input logic [5:0] op);
    case (op)
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ctrl_t blank(input int st);
    ctrl_t w;
    w = '0;
    w.state = 4'(st);
    return w;
  endfunction

  task automatic push(input ctrl_t w, input logic r);
    exp_q.push_back(25'(w));
    rdy_q.push_back(r);
  endtask

  // Expands one instruction into its expected cycle-by-cycle control words
  // and the mem_ready value to drive on each cycle.
  task automatic build_plan(input logic [5:0] op, input logic [5:0] fn, input logic z,
                            input logic lt, input int wf, input int wm, output logic ret);
    ctrl_t w;
    ret = 1'b1;
    for (int i = 0; i < wf; i++) begin
      w = blank(0); w.mem_read = 1; w.alu_src_b = 1; push(w, 1'b0);
    end
    w = blank(0); w.mem_read = 1; w.alu_src_b = 1; w.ir_write = 1; w.pc_write = 1;
    push(w, 1'b1);
    w = blank(1); w.alu_src_b = 3;
    if (!known_op(op)) begin
      w.illegal = 1; push(w, 1'($urandom_range(0, 1))); ret = 1'b0; return;
    end
    push(w, 1'($urandom_range(0, 1)));
    if (op == 6'h00 && fn == 6'h08) begin
      w = blank(13); w.pc_write = 1; w.pc_src = 3; push(w, 1'($urandom_range(0, 1)));
    end else if (op == 6'h00) begin
      for (int i = 0; i < ((fn == 6'h18) ? MUL_CYCLES : 1); i++) begin
        w = blank((fn == 6'h18) ? 3 : 2); w.alu_src_a = 1; w.alu_op = 2;
        push(w, 1'($urandom_range(0, 1)));
      end
      w = blank(8); w.reg_write = 1; w.reg_dst = 1; push(w, 1'($urandom_range(0, 1)));
    end else if (op == 6'h08 || op == 6'h0D || op == 6'h0F) begin
      w = blank(4); w.alu_src_a = 1; w.alu_src_b = 2;
      w.alu_op = (op == 6'h0D) ? 5'd4 : (op == 6'h0F) ? 5'd5 : 5'd0;
      push(w, 1'($urandom_range(0, 1)));
      w = blank(8); w.reg_write = 1; push(w, 1'($urandom_range(0, 1)));
    end else if (op == 6'h23 || op == 6'h2B) begin
      w = blank(5); w.alu_src_a = 1; w.alu_src_b = 2; push(w, 1'($urandom_range(0, 1)));
      for (int i = 0; i <= wm; i++) begin
        w = blank((op == 6'h23) ? 6 : 7); w.i_or_d = 1;
        if (op == 6'h23) w.mem_read = 1; else w.mem_write = 1;
        push(w, (i == wm) ? 1'b1 : 1'b0);
      end
      if (op == 6'h23) begin
        w = blank(9); w.reg_write = 1; w.mem_to_reg = 1; push(w, 1'($urandom_range(0, 1)));
      end
    end else if (op == 6'h02) begin
      w = blank(11); w.pc_write = 1; w.pc_src = 2; push(w, 1'($urandom_range(0, 1)));
    end else if (op == 6'h03) begin
      w = blank(12); w.pc_write = 1; w.pc_src = 2; w.reg_write = 1; w.reg_dst = 2;
      w.mem_to_reg = 2; push(w, 1'($urandom_range(0, 1)));
    end else begin
      w = blank(10); w.alu_src_a = 1; w.alu_op = 1; w.pc_src = 1;
      case (op)
        6'h04:        w.pc_write = z;
        6'h01, 6'h05: w.pc_write = !z;
        6'h06:        w.pc_write = lt;
        default:      w.pc_write = lt | z;
      endcase
      push(w, 1'($urandom_range(0, 1)));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic lt, input int wf, input int wm);
    logic        ret;
    logic [24:0] e;
    int          n;
    build_plan(op, fn, z, lt, wf, wm, ret);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        bus.instr_op_i = op; bus.funct_i = fn; bus.zero_i = z; bus.lt_i = lt;
      end
      bus.mem_ready_i = rdy_q.pop_front();
      #1;
      e = exp_q.pop_front();
      check($sformatf("op%02h_cyc%0d", op, i), 32'(dut_word()), 32'(e));
      if (i == 0) check("retired_at_start", bus.retired_o, model_ret);
    end
    if (ret) model_ret = model_ret + 1;
  endtask

  task automatic exec_count(input vec_t v, input int idx);
    int          cyc;
    int          waits;
    logic        pcw, ill, done;
    logic [3:0]  st;
    logic [31:0] start;
    cyc = 0; pcw = 0; ill = 0; done = 0; waits = v.wm; start = bus.retired_o;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      st = bus.state_o;
      if (k > 0 && st == 4'd0) begin
        bus.mem_ready_i = 1'b0;  // park in FETCH for the next driver
        done = 1;
        break;
      end
      if (k == 0) begin
        bus.instr_op_i = v.op; bus.funct_i = v.fn; bus.zero_i = v.z; bus.lt_i = v.lt;
      end
      if ((st == 4'd6 || st == 4'd7) && waits > 0) begin
        bus.mem_ready_i = 1'b0; waits--;
      end else begin
        bus.mem_ready_i = 1'b1;
      end
      #1;
      if (st != 4'd0 && bus.pc_write_o) pcw = 1;
      if (bus.illegal_o) ill = 1;
      cyc++;
    end
    if (!done) check($sformatf("vec%0d_timeout", idx), 32'd0, 32'd1);
    check($sformatf("vec%0d_cycles", idx), 32'(cyc), 32'(v.cycles));
    check($sformatf("vec%0d_pc_write", idx), 32'(pcw), 32'(v.pcw));
    check($sformatf("vec%0d_illegal", idx), 32'(ill), 32'(v.ill));
    check($sformatf("vec%0d_retired", idx), bus.retired_o - start, 32'(v.ret));
    model_ret = model_ret + 32'(v.ret);
  endtask

  // ---------------- stimulus ----------------
  vec_t vecs[18];
  logic [5:0] legal_ops[13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ctrl_t w0;
    logic [5:0] op, fn;

    //            op     fn     z  lt wm cyc ret pcw ill
    vecs[0]  = '{6'h08, 6'h00, 0, 0, 0, 4, 1, 0, 0};  // ADDI
    vecs[1]  = '{6'h0D, 6'h00, 0, 0, 0, 4, 1, 0, 0};  // ORI
    vecs[2]  = '{6'h0F, 6'h00, 0, 0, 0, 4, 1, 0, 0};  // LUI
    vecs[3]  = '{6'h00, 6'h20, 0, 0, 0, 4, 1, 0, 0};  // R add
    vecs[4]  = '{6'h00, 6'h18, 0, 0, 0, 7, 1, 0, 0};  // MUL
    vecs[5]  = '{6'h00, 6'h08, 0, 0, 0, 3, 1, 1, 0};  // JR
    vecs[6]  = '{6'h02, 6'h00, 0, 0, 0, 3, 1, 1, 0};  // J
    vecs[7]  = '{6'h03, 6'h00, 0, 0, 0, 3, 1, 1, 0};  // JAL
    vecs[8]  = '{6'h23, 6'h00, 0, 0, 3, 8, 1, 0, 0};  // LW, 3 stall cycles
    vecs[9]  = '{6'h2B, 6'h00, 0, 0, 2, 6, 1, 0, 0};  // SW, 2 stall cycles
    vecs[10] = '{6'h04, 6'h00, 1, 0, 0, 3, 1, 1, 0};  // BEQ taken
    vecs[11] = '{6'h04, 6'h00, 0, 0, 0, 3, 1, 0, 0};  // BEQ not taken
    vecs[12] = '{6'h05, 6'h00, 0, 0, 0, 3, 1, 1, 0};  // BNE taken
    vecs[13] = '{6'h01, 6'h00, 1, 0, 0, 3, 1, 0, 0};  // BNEZ not taken
    vecs[14] = '{6'h06, 6'h00, 0, 0, 0, 3, 1, 0, 0};  // BLT lt=0
    vecs[15] = '{6'h07, 6'h00, 1, 0, 0, 3, 1, 1, 0};  // BLE zero=1
    vecs[16] = '{6'h07, 6'h00, 0, 0, 0, 3, 1, 0, 0};  // BLE not taken
    vecs[17] = '{6'h3F, 6'h00, 0, 0, 0, 2, 0, 0, 1};  // illegal

    bus.instr_op_i = 6'h08; bus.funct_i = 6'h00; bus.zero_i = 1'b1;
    bus.lt_i = 1'b1; bus.mem_ready_i = 1'b1;

    // Reset: two cycles, all outputs low, state FETCH.
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      check("reset_word", 32'(dut_word()), 32'd0);
      check("reset_retired", bus.retired_o, 32'd0);
    end
    bus.mem_ready_i = 1'b0;
    rst = 1'b1;

    // Hand sequences: ADDI, LW with 3-cycle memory stall, MUL, BLE/BLT, illegal.
    run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 1'b0, 0, 3);
    run_instr(6'h00, 6'h18, 1'b0, 1'b0, 0, 0);
    run_instr(6'h07, 6'h00, 1'b1, 1'b0, 0, 0);
    run_instr(6'h06, 6'h00, 1'b0, 1'b0, 0, 0);
    run_instr(6'h3F, 6'h00, 1'b0, 1'b0, 1, 0);

    // Table-driven vectors.
    for (int i = 0; i < 18; i++) exec_count(vecs[i], i);

    // Randomized instructions against the cycle-plan model.
    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 12)];
      case ($urandom_range(0, 3))
        0:       fn = 6'h08;
        1:       fn = 6'h18;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    // Reset while a store is waiting in MEM_WR.
    @(negedge clk);
    bus.instr_op_i = 6'h2B; bus.funct_i = 6'h00; bus.mem_ready_i = 1'b1;
    #1 check("sw_fetch_state", 32'(bus.state_o), 32'd0);
    @(negedge clk); #1 check("sw_decode_state", 32'(bus.state_o), 32'd1);
    @(negedge clk); #1 check("sw_addr_state", 32'(bus.state_o), 32'd5);
    @(negedge clk);
    bus.mem_ready_i = 1'b0;
    #1;
    check("sw_memwr_state", 32'(bus.state_o), 32'd7);
    check("sw_mem_write_before_rst", 32'(bus.mem_write_o), 32'd1);
    rst = 1'b0;
    #1;
    w0 = '0;
    w0.state = 4'd7;
    check("sw_rst_same_cycle_word", 32'(dut_word()), 32'(w0));
    check("sw_rst_retired_forced", bus.retired_o, 32'd0);
    @(posedge clk); #1;
    check("sw_rst_next_state", 32'(bus.state_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_ret = 0;

    run_instr(6'h08, 6'h00, 1'b0, 1'b0, 0, 0);
    @(negedge clk); #1;
    check("final_retired", bus.retired_o, model_ret);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
